plot_port_scheduler: RTL and testbench
======================================

// Module: plot_port_scheduler
// PURPOSE
//  Shares the single VGA adapter plot port between three pixel requesters: 0 = background
//  clear, 1 = song-note lanes, 2 = player pitch marker. Each frame_start pulse (from the
//  song-beat FSM's draw-screen state) runs one frame: CLEAR, then NOTES, then PLAYER. While
//  idle it streams live player-marker pixels and drives ready_for_song back to the beat FSM.
// PARAMETERS
//  X_W      8      x coordinate width (160-wide screen)
//  Y_W      7      y coordinate width (120-high screen)
//  C_W      3      colour width
//  TIMEOUT  1024   idle cycles allowed in one phase before it is aborted (>=2)
// PORTS
//  clock           in   1       system clock; only clock domain
//  resetn          in   1       asynchronous, active-low reset
//  frame_start     in   1       1-cycle pulse: start one frame
//  req_valid       in   3       per-requester pixel valid, bit r = requester r
//  req_last        in   3       marks the requester's final pixel of the phase
//  req_x           in   3*X_W   packed x, requester r at [r*X_W +: X_W]
//  req_y           in   3*Y_W   packed y, same packing
//  req_colour      in   3*C_W   packed colour, same packing
//  grant           out  3       one-hot: requester allowed to transfer this cycle
//  vga_x           out  X_W     registered pixel x to adapter
//  vga_y           out  Y_W     registered pixel y
//  vga_colour      out  C_W     registered colour
//  vga_plot        out  1       adapter write enable, 1 cycle per pixel
//  ready_for_song  out  1       high exactly when state is IDLE
//  frame_done      out  1       1-cycle pulse as a frame completes
//  timeout_err     out  1       sticky: some phase hit TIMEOUT
//  overrun_cnt     out  4       saturating count of frame_start pulses ignored while busy
// BEHAVIOUR
//  - Reset (resetn=0, async): state IDLE, grant=3'b100, ready_for_song=1, vga_plot=0,
//    vga_x/y/colour=0, frame_done=0, timeout_err=0, overrun_cnt=0, phase timer=0.
//    Reset mid-frame drops any in-flight pixel; no frame_done is produced.
//  - States: IDLE -> CLEAR -> NOTES -> PLAYER -> DONE -> IDLE.
//    IDLE: frame_start=1 -> CLEAR next cycle. CLEAR/NOTES/PLAYER: advance on transfer with
//    req_last of the granted requester, or on timeout. DONE: one cycle, then IDLE.
//  - grant is combinational from state only: IDLE 100, CLEAR 001, NOTES 010, PLAYER 100,
//    DONE 000. Non-granted req_valid is ignored; requesters hold data until granted.
//  - Transfer = req_valid[r] & grant[r]. Next cycle: vga_plot=1 and vga_x/y/colour = the
//    transferred values (latency 1). No transfer -> vga_plot=0, coordinates hold.
//  - In IDLE req_last[2] is ignored; player pixels stream with no state change.
//  - Simultaneous frame_start and player transfer in IDLE: pixel is plotted; state -> CLEAR.
//  - Phase timer: cleared on phase entry and on each transfer; else +1. Reaching TIMEOUT-1
//    with no transfer that cycle -> advance to next state, set timeout_err (held until reset).
//  - frame_done=1 for the single cycle state is DONE; ready_for_song=0 from CLEAR to DONE.
//  - frame_start in any state except IDLE is dropped; overrun_cnt += 1, saturating at 15.
//  - One pixel max per cycle; back-to-back transfers within a phase are legal every cycle.
// TESTING
//  - Reset: hold resetn=0 -> grant=100, ready_for_song=1, vga_plot=0, overrun_cnt=0.
//  - Frame: pulse frame_start; CLEAR sends 3 px (last on 3rd), NOTES 2, PLAYER 1 -> six vga_plot
//    pulses in order, each 1 cycle after its transfer, frame_done once, ready_for_song back to 1.
//  - Masking: in NOTES drive req_valid=111 -> only requester 1 granted/plotted; others hold.
//  - Timeout TIMEOUT=8: NOTES never valid -> PLAYER entered after 8 cycles, timeout_err=1 sticky.
//  - Overrun: 17 frame_start pulses during one frame -> overrun_cnt=15, frame runs once.
//  - Idle stream + reset: player px (x=5,y=9,c=3) in IDLE -> plotted with no state change; then
//    resetn=0 in NOTES -> IDLE at once, vga_plot=0, no frame_done.

Source files
------------

// File: rtl/plot_port_scheduler.sv
// rtl/plot_port_scheduler.sv - shares the VGA plot port between clear, notes and player requesters
// Runs CLEAR -> NOTES -> PLAYER per frame_start; streams player pixels while idle.
module plot_port_scheduler #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int C_W     = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             frame_start,
  input  logic [2:0]       req_valid,
  input  logic [2:0]       req_last,
  input  logic [3*X_W-1:0] req_x,
  input  logic [3*Y_W-1:0] req_y,
  input  logic [3*C_W-1:0] req_colour,
  output logic [2:0]       grant,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [C_W-1:0]   vga_colour,
  output logic             vga_plot,
  output logic             ready_for_song,
  output logic             frame_done,
  output logic             timeout_err,
  output logic [3:0]       overrun_cnt
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, NOTES, PLAYER, DONE} stateT;

  stateT          state, stateNext;
  logic [TW-1:0]  phaseTimer;
  logic           inPhase;
  logic           anyXfer;
  logic           lastHit;
  logic           timerExpired;
  logic [X_W-1:0] selX;
  logic [Y_W-1:0] selY;
  logic [C_W-1:0] selC;

  always_comb begin
    grant = 3'b000;
    selX  = req_x[2*X_W +: X_W];
    selY  = req_y[2*Y_W +: Y_W];
    selC  = req_colour[2*C_W +: C_W];
    case (state)
      IDLE:   grant = 3'b100;
      CLEAR: begin
        grant = 3'b001;
        selX  = req_x[0 +: X_W];
        selY  = req_y[0 +: Y_W];
        selC  = req_colour[0 +: C_W];
      end
      NOTES: begin
        grant = 3'b010;
        selX  = req_x[X_W +: X_W];
        selY  = req_y[Y_W +: Y_W];
        selC  = req_colour[C_W +: C_W];
      end
      PLAYER: grant = 3'b100;
      default: grant = 3'b000;
    endcase
  end

  assign inPhase      = (state == CLEAR) || (state == NOTES) || (state == PLAYER);
  assign anyXfer      = |(req_valid & grant);
  // req_last only matters inside a phase; the idle player stream never ends a frame
  assign lastHit      = inPhase && |(req_valid & req_last & grant);
  assign timerExpired = inPhase && !anyXfer && (phaseTimer == TIMER_MAX);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (frame_start) stateNext = CLEAR;
      CLEAR:   if (lastHit || timerExpired) stateNext = NOTES;
      NOTES:   if (lastHit || timerExpired) stateNext = PLAYER;
      PLAYER:  if (lastHit || timerExpired) stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  assign ready_for_song = (state == IDLE);
  assign frame_done     = (state == DONE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      phaseTimer  <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      timeout_err <= 1'b0;
      overrun_cnt <= 4'd0;
    end else begin
      state    <= stateNext;
      vga_plot <= anyXfer;
      if (anyXfer) begin
        vga_x      <= selX;
        vga_y      <= selY;
        vga_colour <= selC;
      end
      if (!inPhase || anyXfer || (stateNext != state))
        phaseTimer <= '0;
      else
        phaseTimer <= phaseTimer + 1'b1;
      if (timerExpired)
        timeout_err <= 1'b1;
      if (frame_start && (state != IDLE) && (overrun_cnt != 4'hF))
        overrun_cnt <= overrun_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_plot_port_scheduler.sv
// tb/tb_plot_port_scheduler.sv - scoreboard bench for plot_port_scheduler
module tb_plot_port_scheduler;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        frameStart = 1'b0;
  logic [2:0]  reqValid = '0;
  logic [2:0]  reqLast = '0;
  logic [23:0] reqX = '0;
  logic [20:0] reqY = '0;
  logic [8:0]  reqColour = '0;
  logic [2:0]  grant;
  logic [7:0]  vgaX;
  logic [6:0]  vgaY;
  logic [2:0]  vgaColour;
  logic        vgaPlot;
  logic        readyForSong;
  logic        frameDone;
  logic        timeoutErr;
  logic [3:0]  overrunCnt;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         cyc;
  } pixT;

  pixT expQ[$];
  int  cyc = 0;
  int  doneCnt = 0;
  int  nCompared = 0;
  int  nMismatched = 0;
  int  doneBefore;

  plot_port_scheduler #(.X_W(8), .Y_W(7), .C_W(3), .TIMEOUT(8)) dut (
    .clock(clock), .resetn(resetn), .frame_start(frameStart),
    .req_valid(reqValid), .req_last(reqLast),
    .req_x(reqX), .req_y(reqY), .req_colour(reqColour),
    .grant(grant), .vga_x(vgaX), .vga_y(vgaY), .vga_colour(vgaColour),
    .vga_plot(vgaPlot), .ready_for_song(readyForSong), .frame_done(frameDone),
    .timeout_err(timeoutErr), .overrun_cnt(overrunCnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCompared++;
    if (obs !== expv) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clock) begin
    if (frameDone) doneCnt++;
    if (vgaPlot) begin
      if (expQ.size() == 0) begin
        checkEq("unexpected_plot", vgaPlot, 1'b0);
      end else begin
        pixT e;
        e = expQ.pop_front();
        checkEq("plot_x", vgaX, e.x);
        checkEq("plot_y", vgaY, e.y);
        checkEq("plot_colour", vgaColour, e.c);
        checkEq("plot_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic setSlot(input int r, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    reqX[r*8 +: 8]      = x;
    reqY[r*7 +: 7]      = y;
    reqColour[r*3 +: 3] = c;
  endtask

  task automatic drivePx(input int r, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c, input logic last);
    pixT e;
    logic [2:0] g;
    g = '0;
    g[r] = 1'b1;
    setSlot(r, x, y, c);
    reqValid = '0;
    reqValid[r] = 1'b1;
    reqLast = '0;
    reqLast[r] = last;
    e.x = x; e.y = y; e.c = c; e.cyc = cyc + 1;
    expQ.push_back(e);
    @(negedge clock);
    checkEq("grant", grant, g);
    tick();
    reqValid = '0;
    reqLast = '0;
  endtask

  task automatic startFrame;
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
  endtask

  initial begin
    pixT e;
    // reset state
    #12;
    checkEq("rst_grant", grant, 3'b100);
    checkEq("rst_ready", readyForSong, 1'b1);
    checkEq("rst_plot", vgaPlot, 1'b0);
    checkEq("rst_overrun", overrunCnt, 4'd0);
    checkEq("rst_done", frameDone, 1'b0);
    checkEq("rst_timeout", timeoutErr, 1'b0);
    checkEq("rst_xyc", {vgaX, vgaY, vgaColour}, 18'd0);
    tick();
    resetn = 1'b1;
    tick();

    // normal frame: 3 clear, 2 notes, 1 player pixel
    startFrame();
    checkEq("frame_ready_low", readyForSong, 1'b0);
    drivePx(0, 8'd1, 7'd1, 3'd1, 1'b0);
    drivePx(0, 8'd2, 7'd2, 3'd2, 1'b0);
    drivePx(0, 8'd159, 7'd119, 3'd7, 1'b1);
    drivePx(1, 8'd40, 7'd20, 3'd4, 1'b0);
    drivePx(1, 8'd41, 7'd21, 3'd5, 1'b1);
    drivePx(2, 8'd80, 7'd60, 3'd6, 1'b1);
    checkEq("frame_done_hi", frameDone, 1'b1);
    checkEq("done_grant", grant, 3'b000);
    checkEq("done_ready", readyForSong, 1'b0);
    tick();
    checkEq("frame_done_lo", frameDone, 1'b0);
    checkEq("frame_ready_back", readyForSong, 1'b1);
    checkEq("frame_done_cnt", doneCnt, 1);
    checkEq("frame_no_timeout", timeoutErr, 1'b0);

    // masking: every requester valid in NOTES
    startFrame();
    drivePx(0, 8'd3, 7'd3, 3'd3, 1'b1);
    setSlot(0, 8'hAA, 7'h2A, 3'd1);
    setSlot(1, 8'd50, 7'd51, 3'd2);
    setSlot(2, 8'd70, 7'd71, 3'd3);
    reqValid = 3'b111;
    reqLast = 3'b101;
    e.x = 8'd50; e.y = 7'd51; e.c = 3'd2; e.cyc = cyc + 1;
    expQ.push_back(e);
    @(negedge clock);
    checkEq("mask_grant", grant, 3'b010);
    tick();
    setSlot(1, 8'd52, 7'd53, 3'd4);
    reqLast = 3'b111;
    e.x = 8'd52; e.y = 7'd53; e.c = 3'd4; e.cyc = cyc + 1;
    expQ.push_back(e);
    tick();
    checkEq("mask_player_grant", grant, 3'b100);
    e.x = 8'd70; e.y = 7'd71; e.c = 3'd3; e.cyc = cyc + 1;
    expQ.push_back(e);
    tick();
    reqValid = '0;
    reqLast = '0;
    checkEq("mask_done", frameDone, 1'b1);
    tick();
    checkEq("mask_done_cnt", doneCnt, 2);

    // timeout in NOTES
    startFrame();
    drivePx(0, 8'd4, 7'd4, 3'd4, 1'b1);
    repeat (7) tick();
    checkEq("to_still_notes", grant, 3'b010);
    checkEq("to_err_early", timeoutErr, 1'b0);
    tick();
    checkEq("to_player", grant, 3'b100);
    checkEq("to_err_set", timeoutErr, 1'b1);
    drivePx(2, 8'd9, 7'd9, 3'd1, 1'b1);
    tick();
    checkEq("to_ready", readyForSong, 1'b1);
    checkEq("to_err_sticky", timeoutErr, 1'b1);

    // overrun: 17 pulses while busy
    doneBefore = doneCnt;
    startFrame();
    frameStart = 1'b1;
    repeat (17) tick();
    frameStart = 1'b0;
    for (int i = 0; i < 40 && !readyForSong; i++) tick();
    checkEq("ovr_back_idle", readyForSong, 1'b1);
    checkEq("ovr_cnt", overrunCnt, 4'd15);
    repeat (3) tick();
    checkEq("ovr_stay_idle", readyForSong, 1'b1);
    checkEq("ovr_one_frame", doneCnt - doneBefore, 1);

    // idle stream, simultaneous frame_start, then reset mid NOTES
    drivePx(2, 8'd5, 7'd9, 3'd3, 1'b1);
    checkEq("idle_stay", readyForSong, 1'b1);
    frameStart = 1'b1;
    drivePx(2, 8'd6, 7'd10, 3'd2, 1'b0);
    frameStart = 1'b0;
    checkEq("sim_clear", grant, 3'b001);
    drivePx(0, 8'd7, 7'd11, 3'd1, 1'b1);
    doneBefore = doneCnt;
    setSlot(1, 8'd99, 7'd99, 3'd7);
    reqValid = 3'b010;
    @(negedge clock);
    resetn = 1'b0;
    #1;
    checkEq("mrst_grant", grant, 3'b100);
    checkEq("mrst_ready", readyForSong, 1'b1);
    checkEq("mrst_plot", vgaPlot, 1'b0);
    tick();
    checkEq("mrst_plot_held", vgaPlot, 1'b0);
    checkEq("mrst_overrun", overrunCnt, 4'd0);
    checkEq("mrst_timeout", timeoutErr, 1'b0);
    reqValid = '0;
    resetn = 1'b1;
    repeat (2) tick();
    checkEq("mrst_no_done", doneCnt - doneBefore, 0);
    checkEq("queue_empty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
